// File: rtl/mem_access_pkg.sv
// Shared encodings and request checks for the load/store unit and its lane aligner.
package mem_access_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned MEM_BYTES_DEFAULT = 64;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_e;

    typedef struct packed {
        logic            write;
        size_e           size;
        logic            sign_ext;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    function automatic logic [2:0] size_bytes(input size_e size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Illegal size, misalignment, or any byte beyond the RAM makes a request an error.
    function automatic logic req_error(input size_e size, input logic [XLEN-1:0] addr,
                                       input int unsigned mem_bytes);
        logic          err;
        logic [XLEN:0] end_addr;
        end_addr = {1'b0, addr} + (XLEN+1)'(size_bytes(size));
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr[0];
            SZ_WORD: err = (addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        if (end_addr > (XLEN+1)'(mem_bytes)) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian lane extraction/extension for loads and byte-lane merge for sub-word stores.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  size_e           size_i,
    input  logic            sign_ext_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] mem_word_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [XLEN-1:0] load_data_c_o,
    output logic [XLEN-1:0] merged_word_c_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    logic [4:0]        byte_shift;
    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    // Byte offset 0 sits in the most significant lane.
    assign byte_shift = {~offset_i, 3'b000};
    assign byte_lane  = mem_word_i[byte_shift +: BYTE_W];
    assign half_lane  = offset_i[1] ? mem_word_i[HALF_W-1:0] : mem_word_i[XLEN-1:HALF_W];

    always_comb begin
        load_data_c_o   = '0;
        merged_word_c_o = mem_word_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_c_o = {{(XLEN-BYTE_W){sign_ext_i & byte_lane[BYTE_W-1]}}, byte_lane};
                merged_word_c_o[byte_shift +: BYTE_W] = store_data_i[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_data_c_o = {{(XLEN-HALF_W){sign_ext_i & half_lane[HALF_W-1]}}, half_lane};
                if (offset_i[1]) begin
                    merged_word_c_o[HALF_W-1:0] = store_data_i[HALF_W-1:0];
                end else begin
                    merged_word_c_o[XLEN-1:HALF_W] = store_data_i[HALF_W-1:0];
                end
            end
            SZ_WORD: begin
                load_data_c_o   = mem_word_i;
                merged_word_c_o = store_data_i;
            end
            default: begin
                load_data_c_o   = '0;
                merged_word_c_o = mem_word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a word-wide RAM with negedge-commit writes.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic            reqWrite,
    input  logic [1:0]      reqSize,
    input  logic            reqSigned,
    input  logic [XLEN-1:0] reqAddr,
    input  logic [XLEN-1:0] reqWData,
    output logic            respValid,
    output logic [XLEN-1:0] respRData,
    output logic            respErr,
    output logic [XLEN-1:0] memAddress,
    output logic [XLEN-1:0] memWriteData,
    output logic            memRead,
    output logic            memWrite,
    input  logic [XLEN-1:0] memDataOut
);

    state_e          state_q, state_d;
    req_t            req_q, req_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    req_t            req_in_c;
    logic            req_err_c;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] merged_word_c;

    assign req_in_c  = '{write: reqWrite, size: size_e'(reqSize), sign_ext: reqSigned,
                         addr: reqAddr, wdata: reqWData};
    assign req_err_c = req_error(req_in_c.size, reqAddr, MEM_BYTES);

    mem_lane_align u_lane_align (
        .size_i          (req_q.size),
        .sign_ext_i      (req_q.sign_ext),
        .offset_i        (req_q.addr[1:0]),
        .mem_word_i      (memDataOut),
        .store_data_i    (req_q.wdata),
        .load_data_c_o   (load_data_c),
        .merged_word_c_o (merged_word_c)
    );

    // Next state plus registered copies of every output, decoded from the upcoming state.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_wdata_d = '0;
        case (state_q)
            IDLE: begin
                if (reqValid && ready_q) begin
                    req_d   = req_in_c;
                    err_d   = req_err_c;
                    rdata_d = '0;
                    if (req_err_c) begin
                        state_d = RESP;
                    end else if (!reqWrite) begin
                        state_d = RD;
                    end else if (req_in_c.size == SZ_WORD) begin
                        state_d     = WR;
                        mem_wdata_d = reqWData;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD: begin
                rdata_d = load_data_c;
                state_d = RESP;
            end
            RMW_RD: begin
                mem_wdata_d = merged_word_c;
                state_d     = WR;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d      = (state_d == IDLE);
        mem_read_d   = (state_d == RD) || (state_d == RMW_RD);
        mem_write_d  = (state_d == WR);
        mem_addr_d   = (mem_read_d || mem_write_d) ? {req_d.addr[XLEN-1:2], 2'b00} : '0;
        // The pulse lands in the IDLE cycle after RESP, which is also open for a new request.
        resp_valid_d = (state_q == RESP);
        resp_err_d   = (state_q == RESP) && err_q;
        resp_rdata_d = (state_q == RESP) ? rdata_q : '0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            req_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign reqReady     = ready_q;
    assign respValid    = resp_valid_q;
    assign respErr      = resp_err_q;
    assign respRData    = resp_rdata_q;
    assign memRead      = mem_read_q;
    assign memWrite     = mem_write_q;
    assign memAddress   = mem_addr_q;
    assign memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and back-to-back checks of mem_access_unit against a 64-byte big-endian RAM.
module tb_mem_access_unit;

    localparam int unsigned MEM_BYTES = 64;
    localparam int          NV        = 22;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        reqValid, reqReady, reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqWData;
    logic        respValid, respErr;
    logic [31:0] respRData;
    logic [31:0] memAddress, memWriteData, memDataOut;
    logic        memRead, memWrite;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqWrite     (reqWrite),
        .reqSize      (reqSize),
        .reqSigned    (reqSigned),
        .reqAddr      (reqAddr),
        .reqWData     (reqWData),
        .respValid    (respValid),
        .respRData    (respRData),
        .respErr      (respErr),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memDataOut   (memDataOut)
    );

    always #5 CLK = ~CLK;

    // Attached RAM: combinational big-endian read, write commits on negedge.
    logic [7:0] ram   [MEM_BYTES];
    logic [7:0] model [MEM_BYTES];
    logic [5:0] ram_a;
    assign ram_a      = {memAddress[5:2], 2'b00};
    assign memDataOut = {ram[ram_a], ram[ram_a + 6'd1], ram[ram_a + 6'd2], ram[ram_a + 6'd3]};

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_addr = 32'h0;
    logic        both_seen = 1'b0;
    logic        bus_dirty = 1'b0;
    logic        dbl_resp  = 1'b0;
    logic        prev_rv   = 1'b0;

    always @(negedge CLK) begin
        if (memWrite) begin
            ram[ram_a]        = memWriteData[31:24];
            ram[ram_a + 6'd1] = memWriteData[23:16];
            ram[ram_a + 6'd2] = memWriteData[15:8];
            ram[ram_a + 6'd3] = memWriteData[7:0];
        end
        if (memRead)  begin rd_cnt++; last_addr = memAddress; end
        if (memWrite) begin wr_cnt++; last_addr = memAddress; end
        if (memRead && memWrite) both_seen = 1'b1;
        if (!memRead && !memWrite && (memAddress != 0 || memWriteData != 0)) bus_dirty = 1'b1;
        if (respValid && prev_rv) dbl_resp = 1'b1;
        prev_rv = respValid;
    end

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(a[5:0]);
        case (sz)
            2'b00: begin b = model[i]; return {{24{sg & b[7]}}, b}; end
            2'b01: begin h = {model[i], model[i+1]}; return {{16{sg & h[15]}}, h}; end
            default: return {model[i], model[i+1], model[i+2], model[i+3]};
        endcase
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int i;
        i = int'(a[5:0]);
        case (sz)
            2'b00: model[i] = wd[7:0];
            2'b01: begin model[i] = wd[15:8]; model[i+1] = wd[7:0]; end
            default: begin
                model[i] = wd[31:24]; model[i+1] = wd[23:16];
                model[i+2] = wd[15:8]; model[i+3] = wd[7:0];
            end
        endcase
    endtask

    // Entered at a negedge; returns at the negedge where respValid is seen.
    task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr, output int wait_n);
        int rd0, wr0;
        rd = 32'h0; er = 1'b0; lat = -1; nrd = -1; nwr = -1; wait_n = 0;
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWData = wd;
        while (!reqReady && wait_n < 20) begin
            @(negedge CLK);
            wait_n++;
        end
        if (!reqReady) begin
            checks++; errors++;
            $display("FAIL accept timeout: addr 0x%08h never accepted", a);
            reqValid = 1'b0;
            return;
        end
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(negedge CLK);
        if (!hold) reqValid = 1'b0;
        lat = 0;
        while (!respValid && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        if (!respValid) begin
            checks++; errors++;
            $display("FAIL response timeout: addr 0x%08h got no respValid", a);
            reqValid = 1'b0;
            lat = -1;
            return;
        end
        rd = respRData; er = respErr; nrd = rd_cnt - rd0; nwr = wr_cnt - wr0;
    endtask

    task automatic check_txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, input logic hold,
                             input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                             output int wait_n);
        logic [31:0] rd;
        logic        er;
        int          lat, nrd, nwr, exp_nrd, exp_nwr;
        send(w, sz, sg, a, wd, hold, rd, er, lat, nrd, nwr, wait_n);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " err"}, 32'(er), 32'(exp_err));
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        exp_nrd = (exp_err || (w && sz == 2'b10)) ? 0 : 1;
        exp_nwr = (exp_err || !w) ? 0 : 1;
        check({tag, " ram reads"}, 32'(nrd), 32'(exp_nrd));
        check({tag, " ram writes"}, 32'(nwr), 32'(exp_nwr));
        if (!exp_err) begin
            check({tag, " ram addr"}, last_addr, {a[31:2], 2'b00});
            if (w) model_store(sz, a, wd);
        end
    endtask

    initial begin
        int          wn;
        logic        w, sg;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp_rd;

        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            ram[i]   = 8'(i * 7 + 3);
            model[i] = 8'(i * 7 + 3);
        end

        //             w     sz     sg    addr    wdata         exp_rd        err   lat
        vec[0]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
        vec[1]  = '{1'b0, 2'b00, 1'b0, 32'h08, 32'h0,        32'h000000DE, 1'b0, 2};
        vec[2]  = '{1'b0, 2'b00, 1'b1, 32'h0B, 32'h0,        32'hFFFFFFEF, 1'b0, 2};
        vec[3]  = '{1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        32'h0000BEEF, 1'b0, 2};
        vec[4]  = '{1'b1, 2'b00, 1'b0, 32'h09, 32'hAAAAAA55, 32'h00000000, 1'b0, 3};
        vec[5]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDE55BEEF, 1'b0, 2};
        vec[6]  = '{1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,        32'hFFFFBEEF, 1'b0, 2};
        vec[7]  = '{1'b1, 2'b01, 1'b0, 32'h0A, 32'hFFFF1234, 32'h00000000, 1'b0, 3};
        vec[8]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDE551234, 1'b0, 2};
        vec[9]  = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h00000000, 1'b1, 1};
        vec[10] = '{1'b1, 2'b01, 1'b0, 32'h03, 32'hCAFE,     32'h00000000, 1'b1, 1};
        vec[11] = '{1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,        32'hA7AEB5BC, 1'b0, 2};
        vec[12] = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'h00000000, 1'b1, 1};
        vec[13] = '{1'b0, 2'b01, 1'b0, 32'h3F, 32'h0,        32'h00000000, 1'b1, 1};
        vec[14] = '{1'b0, 2'b01, 1'b1, 32'h3E, 32'h0,        32'hFFFFB5BC, 1'b0, 2};
        vec[15] = '{1'b0, 2'b00, 1'b0, 32'h3F, 32'h0,        32'h000000BC, 1'b0, 2};
        vec[16] = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b1, 1};
        vec[17] = '{1'b0, 2'b00, 1'b1, 32'h3C, 32'h0,        32'hFFFFFFA7, 1'b0, 2};
        vec[18] = '{1'b1, 2'b00, 1'b0, 32'h40, 32'h11,       32'h00000000, 1'b1, 1};
        vec[19] = '{1'b1, 2'b00, 1'b0, 32'h3F, 32'h00000080, 32'h00000000, 1'b0, 3};
        vec[20] = '{1'b0, 2'b00, 1'b1, 32'h3F, 32'h0,        32'hFFFFFF80, 1'b0, 2};
        vec[21] = '{1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,        32'hA7AEB580, 1'b0, 2};

        RSTn = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
        reqAddr = 32'h0; reqWData = 32'h0;
        #1 RSTn = 1'b0;
        #2;
        check("reset reqReady", 32'(reqReady), 32'h0);
        check("reset respValid", 32'(respValid), 32'h0);
        check("reset respErr", 32'(respErr), 32'h0);
        check("reset respRData", respRData, 32'h0);
        check("reset memRead", 32'(memRead), 32'h0);
        check("reset memWrite", 32'(memWrite), 32'h0);
        check("reset memAddress", memAddress, 32'h0);
        check("reset memWriteData", memWriteData, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        check("ready after release", 32'(reqReady), 32'h1);

        for (int i = 0; i < NV; i++) begin
            check_txn($sformatf("vec%0d", i), vec[i].w, vec[i].sz, vec[i].sg, vec[i].addr, vec[i].wd,
                      1'b0, vec[i].exp_rd, vec[i].exp_err, vec[i].exp_lat, wn);
        end

        // Reset lands while the word store sits in WR, before the RAM's negedge commit.
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqSigned = 1'b0;
        reqAddr = 32'h10; reqWData = 32'h12345678;
        check("wr-reset ready", 32'(reqReady), 32'h1);
        @(posedge CLK);
        #1;
        check("wr-reset in WR", 32'(memWrite), 32'h1);
        RSTn = 1'b0;
        #1;
        check("wr-reset memWrite", 32'(memWrite), 32'h0);
        check("wr-reset memAddress", memAddress, 32'h0);
        check("wr-reset memWriteData", memWriteData, 32'h0);
        check("wr-reset reqReady", 32'(reqReady), 32'h0);
        check("wr-reset respValid", 32'(respValid), 32'h0);
        reqValid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("wr-reset respValid held", 32'(respValid), 32'h0);
        RSTn = 1'b1;
        @(negedge CLK);
        check("wr-reset ready after release", 32'(reqReady), 32'h1);
        check("wr-reset no stale resp", 32'(respValid), 32'h0);
        check_txn("wr-reset lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h737A8188, 1'b0, 2, wn);

        // Back-to-back legal traffic with reqValid never dropped.
        for (int i = 0; i < 20; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            exp_rd = w ? 32'h0 : model_load(sz, sg, a);
            check_txn($sformatf("b2b%0d", i), w, sz, sg, a, wd, 1'b1, exp_rd, 1'b0,
                      (w && sz != 2'b10) ? 3 : 2, wn);
            check($sformatf("b2b%0d accept wait", i), 32'(wn), 32'h0);
        end
        reqValid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        check("read/write strobes overlap", 32'(both_seen), 32'h0);
        check("bus nonzero without strobe", 32'(bus_dirty), 32'h0);
        check("respValid longer than one cycle", 32'(dbl_resp), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 64, giving the byte capacity of the attached RAM.
REQ-002 SHALL have port CLK  in  1  single system clock; all state updates on posedge.
REQ-003 SHALL have port RSTn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port reqValid  in  1  pipeline request present.
REQ-005 SHALL have port reqReady  out  1  unit can accept a request.
REQ-006 SHALL have port reqWrite  in  1  1 = store, 0 = load.
REQ-007 SHALL have port reqSize  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 SHALL have port reqSigned  in  1  load sign-extends when 1 and zero-extends when 0.
REQ-009 SHALL have port reqAddr  in  32  byte address.
REQ-010 SHALL have port reqWData  in  32  store data, right-justified.
REQ-011 SHALL have port respValid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port respRData  out  32  extended load data.
REQ-013 SHALL have port respErr  out  1  request rejected; valid with respValid.
REQ-014 SHALL have port memAddress  out  32  RAM byte address, word-aligned.
REQ-015 SHALL have port memWriteData  out  32  RAM write word.
REQ-016 SHALL have port memRead  out  1  RAM read strobe.
REQ-017 SHALL have port memWrite  out  1  RAM write strobe; RAM commits on negedge CLK.
REQ-018 SHALL have port memDataOut  in  32  RAM combinational read word, big-endian.

Function
REQ-019 SHALL use FSM states IDLE, RD, RMW_RD, WR, RESP; reqReady SHALL be 1 only in IDLE.
REQ-020 SHALL latch the request on a posedge with reqValid&reqReady (the acceptance edge, E).
REQ-021 SHALL treat a request as an error and go IDLE->RESP with no RAM access when any of these holds: reqSize=11; a halfword with addr[0]=1; a word with addr[1:0]!=0; addr+bytes>MEM_BYTES.
REQ-022 SHALL route non-error requests from IDLE as follows: load->RD; word store->WR; byte or halfword store->RMW_RD.
REQ-023 SHALL, in RD, drive memRead=1 with memAddress={addr[31:2],2'b00}, capture memDataOut at the next posedge, and go to RESP.
REQ-024 SHALL, in RMW_RD, read the aligned word the same way, merge the new bytes into it, and go to WR at the next posedge.
REQ-025 SHALL, in WR, drive memWrite=1 with the aligned memAddress and the merged or full word, and go to RESP at the next posedge.
REQ-026 SHALL use big-endian lanes: byte offset 0 = bits 31:24 and offset 3 = bits 7:0; half offset 0 = bits 31:16 and offset 2 = bits 15:0.
REQ-027 SHALL, in RESP, pulse respValid=1 for exactly one cycle and then return to IDLE; respRData SHALL be 0 for stores and for errors.
REQ-028 SHALL place respValid in the cycle after these edges: load and word store E+2; sub-word store E+3; error E+1.
REQ-029 SHALL never assert memRead and memWrite together; both SHALL be 0 in IDLE and RESP.
REQ-030 SHALL drive memAddress and memWriteData to 0 whenever no strobe is active.
REQ-031 SHALL ignore reqValid while not in IDLE; callers hold the request until reqReady.
REQ-032 SHALL allow back-to-back requests: a request presented in the RESP-following IDLE cycle is accepted at that edge.

Reset
REQ-033 SHALL, with RSTn=0, immediately force IDLE and all outputs to 0 except reqReady.
REQ-034 SHALL drive reqReady=0 during reset and 1 on the first cycle after release.
REQ-035 SHALL, if reset asserts in WR before negedge CLK, drop memWrite at once so that no RAM write occurs; the pending response SHALL be discarded.

Structure
REQ-036 SHALL keep the size encodings, FSM state encoding, and the MEM_BYTES default in shared package mem_access_pkg.
REQ-037 SHALL keep lane extract/extend and store-merge logic in one combinational sub-module, mem_lane_align.

Verification
REQ-038 SHALL cover a word store then load: store 0xDEADBEEF at 0x08, then lbu 0x08 -> 0x000000DE, lb 0x0B -> 0xFFFFFFEF, lhu 0x0A -> 0x0000BEEF.
REQ-039 SHALL cover a byte store with RMW: after REQ-038, sb 0x55 at 0x09 -> exactly one read and one write at 0x08; lw 0x08 -> 0xDE55BEEF; respValid at E+3.
REQ-040 SHALL cover misalignment: lw 0x06 or sh 0x03 -> respErr=1 at E+1; memRead and memWrite never asserted.
REQ-041 SHALL cover the bounds check: lw 0x3C passes; lw 0x40 and lh 0x3F -> respErr=1 with MEM_BYTES=64.
REQ-042 SHALL cover reset mid-operation: assert RSTn=0 in WR of sw 0x12345678 at 0x10 -> lw 0x10 afterwards returns the prior value; outputs 0 during reset.
REQ-043 SHALL cover back-to-back traffic: 20 random legal requests with reqValid held high -> responses in order, latencies per REQ-028, and the scoreboard matches a byte-array model.
